// File: rtl/regfile_wb_scheduler.sv
// Register-file write-back scheduler: arbitrates ALU/LSU results onto one write port.
// Optional round-robin arbitration is enabled by defining WB_RR_ARB_EN.
module regfile_wb_scheduler #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            stall,
  output logic            RegWrite,
  output logic [4:0]      write_register,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     busy
);

  logic            acc_alu;
  logic            acc_lsu;
  logic            acc;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_data;
  logic [31:0]     busy_nxt;

  assign acc_alu = alu_valid & alu_ready;
  assign acc_lsu = lsu_valid & lsu_ready;
  assign acc     = acc_alu | acc_lsu;

`ifdef WB_RR_ARB_EN
  typedef enum logic {
    PREF_ALU = 1'b0,
    PREF_LSU = 1'b1
  } arb_t;

  arb_t state;
  arb_t state_nxt;

  // Arbitration preference register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PREF_ALU;
    else     state <= state_nxt;
  end

  // Preference moves to the source that was not just served
  always_comb begin
    state_nxt = state;
    if (acc_alu)      state_nxt = PREF_LSU;
    else if (acc_lsu) state_nxt = PREF_ALU;
  end

  // Grant the preferred source on a tie, otherwise whoever is valid
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (alu_valid && (!lsu_valid || state == PREF_ALU))
        alu_ready = 1'b1;
      else if (lsu_valid)
        lsu_ready = 1'b1;
    end
  end
`else
  // Fixed priority grant: ALU always wins a tie
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (alu_valid)      alu_ready = 1'b1;
      else if (lsu_valid) lsu_ready = 1'b1;
    end
  end
`endif

  // Select the payload of the accepted source
  always_comb begin
    acc_rd   = 5'd0;
    acc_data = '0;
    unique case (1'b1)
      acc_alu: begin
        acc_rd   = alu_rd;
        acc_data = alu_data;
      end
      acc_lsu: begin
        acc_rd   = lsu_rd;
        acc_data = lsu_data;
      end
      default: ;
    endcase
  end

  // Register the write port; x0 writes are swallowed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite       <= 1'b0;
      write_register <= 5'd0;
      write_data     <= '0;
    end else if (acc && acc_rd != 5'd0) begin
      RegWrite       <= 1'b1;
      write_register <= acc_rd;
      write_data     <= acc_data;
    end else begin
      RegWrite       <= 1'b0;
    end
  end

  // Scoreboard update: clear on write, then set on issue so set wins
  always_comb begin
    busy_nxt = busy;
    if (RegWrite)
      busy_nxt[write_register] = 1'b0;
    if (issue_valid && issue_rd != 5'd0)
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Hazard check against the registered scoreboard only
  always_comb begin
    stall = busy[rs1] | busy[rs2];
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler.
// Expectations follow WB_RR_ARB_EN when the bench is built with it.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        RegWrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  regfile_wb_scheduler #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .alu_valid(alu_valid),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .alu_ready(alu_ready),
    .lsu_valid(lsu_valid),
    .lsu_rd(lsu_rd),
    .lsu_data(lsu_data),
    .lsu_ready(lsu_ready),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .rs1(rs1),
    .rs2(rs2),
    .stall(stall),
    .RegWrite(RegWrite),
    .write_register(write_register),
    .write_data(write_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1 = '0; rs2 = '0;

    // Reset state, request during reset is refused
    #2;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h11;
    #1;
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    tick();
    check("rst_no_accept", {31'd0, RegWrite}, 32'd0);
    check("rst_wdata", write_data, 32'd0);
    alu_valid = 1'b0;
    rst = 1'b0;

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hBEEFBEEF;
    #1;
    check("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("t1_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    tick();
    alu_valid = 1'b0;
    check("t1_regwrite", {31'd0, RegWrite}, 32'd1);
    check("t1_wreg", {27'd0, write_register}, 32'd1);
    check("t1_wdata", write_data, 32'hBEEFBEEF);
    tick();
    check("t1_pulse_end", {31'd0, RegWrite}, 32'd0);
    check("t1_wdata_hold", write_data, 32'hBEEFBEEF);

    // Simultaneous requests from reset
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h12345678;
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hCAFEF00D;
    #1;
    check("t2_alu_first", {31'd0, alu_ready}, 32'd1);
    check("t2_lsu_wait", {31'd0, lsu_ready}, 32'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    check("t2_wb_x2_we", {31'd0, RegWrite}, 32'd1);
    check("t2_wb_x2_rd", {27'd0, write_register}, 32'd2);
    check("t2_wb_x2_data", write_data, 32'h12345678);
    check("t2_lsu_second", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    check("t2_wb_x3_we", {31'd0, RegWrite}, 32'd1);
    check("t2_wb_x3_rd", {27'd0, write_register}, 32'd3);
    check("t2_wb_x3_data", write_data, 32'hCAFEF00D);
    tick();
    check("t2_idle", {31'd0, RegWrite}, 32'd0);

    // Sustained contention for four cycles
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hA4;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'hB6;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef WB_RR_ARB_EN
      check($sformatf("t3_alu_%0d", i), {31'd0, alu_ready},
            (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t3_lsu_%0d", i), {31'd0, lsu_ready},
            (i % 2 == 1) ? 32'd1 : 32'd0);
`else
      check($sformatf("t3_alu_%0d", i), {31'd0, alu_ready}, 32'd1);
      check($sformatf("t3_lsu_%0d", i), {31'd0, lsu_ready}, 32'd0);
`endif
      tick();
    end
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    tick();
    tick();

    // LSU write to x0
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    check("t4_busy_pre", busy, 32'h80);
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFFFFFF;
    #1;
    check("t4_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    check("t4_no_we", {31'd0, RegWrite}, 32'd0);
    tick();
    check("t4_no_we2", {31'd0, RegWrite}, 32'd0);
    check("t4_busy", busy, 32'h80);

    // RAW hazard tracking on x5
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    rs1 = 5'd5;
    #1;
    check("t5_busy_set", busy, 32'hA0);
    check("t5_stall", {31'd0, stall}, 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h55;
    tick();
    alu_valid = 1'b0;
    check("t5_we", {31'd0, RegWrite}, 32'd1);
    check("t5_no_fwd", {31'd0, stall}, 32'd1);
    tick();
    check("t5_busy_clr", busy, 32'h80);
    check("t5_stall_clr", {31'd0, stall}, 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h56;
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd5;
    check("t5_we2", {31'd0, RegWrite}, 32'd1);
    tick();
    issue_valid = 1'b0;
    check("t5_set_wins", busy, 32'hA0);
    check("t5_stall_again", {31'd0, stall}, 32'd1);
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    check("t5_stall_rs2", {31'd0, stall}, 32'd1);
    rs2 = 5'd0;

    // Asynchronous reset mid-cycle
    do_reset();
    check("t6_busy_rst", busy, 32'd0);
    issue_valid = 1'b1; issue_rd = 5'd2;
    tick();
    issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    check("t6_busy_24", busy, 32'h24);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    tick();
    alu_rd = 5'd10; alu_data = 32'hAA;
    #1;
    check("t6_we_pre", {31'd0, RegWrite}, 32'd1);
    check("t6_grant_pre", {31'd0, alu_ready}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_busy", busy, 32'd0);
    check("t6_we", {31'd0, RegWrite}, 32'd0);
    check("t6_wreg", {27'd0, write_register}, 32'd0);
    check("t6_wdata", write_data, 32'd0);
    check("t6_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("t6_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    tick();
    check("t6_discard", {31'd0, RegWrite}, 32'd0);
    alu_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("t6_after", {31'd0, RegWrite}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each write-back value and of write_data.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 SHALL have ports alu_valid in 1, alu_rd in 5, alu_data in XLEN, which together form the ALU write-back request.
REQ-005 SHALL have port alu_ready, out, 1 bit, which accepts the ALU request in the cycle it is high together with alu_valid.
REQ-006 SHALL have ports lsu_valid in 1, lsu_rd in 5, lsu_data in XLEN, which together form the load-unit write-back request.
REQ-007 SHALL have port lsu_ready, out, 1 bit, which accepts the LSU request in the cycle it is high together with lsu_valid.
REQ-008 SHALL have ports issue_valid in 1, issue_rd in 5, which mark an issued instruction's destination register as pending.
REQ-009 SHALL have ports rs1 in 5, rs2 in 5, which are the source registers of the instruction in decode.
REQ-010 SHALL have port stall, out, 1 bit, a read-after-write hazard indication for rs1/rs2.
REQ-011 SHALL have ports RegWrite out 1, write_register out 5, write_data out XLEN, which drive the register file write port.
REQ-012 SHALL have port busy, out, 32 bits, the pending-write scoreboard, where bit i = register i.

Function
REQ-013 SHALL accept at most one write-back request per cycle: ready goes only to the granted source; the non-granted source keeps valid and its payload stable until accepted.
REQ-014 SHALL drive alu_ready/lsu_ready combinationally from the current valids and arbitration state; a source with valid low SHALL NOT be granted.
REQ-015 SHALL, when exactly one source is valid, grant that source in the same cycle.
REQ-016 SHALL register an accepted request with rd!=0 into RegWrite=1, write_register=rd, write_data=data one cycle after acceptance (latency 1); RegWrite SHALL be high for exactly one cycle per such request.
REQ-017 SHALL accept a request with rd=0 normally, but produce no RegWrite pulse and change no busy bit.
REQ-018 SHALL, when no request is accepted, drive RegWrite=0 on the next cycle; write_register/write_data SHALL then hold their last values.
REQ-019 SHALL set busy[issue_rd] at the clock edge where issue_valid=1, except that issue_rd=0 SHALL be ignored.
REQ-020 SHALL clear busy[write_register] at the clock edge where RegWrite=1.
REQ-021 SHALL, when a set and a clear hit the same register at the same edge, leave the bit set (set wins).
REQ-022 SHALL hold busy[0]=0 at all times.
REQ-023 SHALL drive stall = busy[rs1] | busy[rs2], combinationally from the current busy vector, with no same-cycle forwarding from RegWrite.

Reset
REQ-024 SHALL, while rst=1, force RegWrite=0, write_register=0, write_data=0, busy=0 and the arbitration state to "ALU preferred", immediately and without waiting for clk.
REQ-025 SHALL, while rst=1, drive alu_ready=0 and lsu_ready=0; a request presented during reset SHALL NOT be accepted, and a write pending at reset assertion SHALL be discarded.

Configuration
REQ-026 SHALL support macro WB_RR_ARB_EN; when it is defined, simultaneous ALU and LSU requests are arbitrated round-robin: the preferred source is granted, then preference moves to the other source.
REQ-027 SHALL, when WB_RR_ARB_EN is undefined, use fixed priority with ALU over LSU on simultaneous requests; no arbitration state is kept, and the LSU waits as long as ALU requests continue.

Verification
REQ-028 Bench SHALL cover: ALU valid, rd=1, data=0xBEEFBEEF, alone -> alu_ready=1 the same cycle; next cycle RegWrite=1, write_register=1, write_data=0xBEEFBEEF for one cycle.
REQ-029 Bench SHALL cover: ALU rd=2 data=0x12345678 and LSU rd=3 data=0xCAFEF00D both valid from reset -> ALU granted first, LSU second; RegWrite pulses on two consecutive cycles for x2 then x3 (both macro settings).
REQ-030 Bench SHALL cover, with WB_RR_ARB_EN defined: both sources held valid for 4 cycles -> grants alternate ALU, LSU, ALU, LSU; with it undefined -> ALU granted all 4 cycles and lsu_ready stays 0.
REQ-031 Bench SHALL cover: LSU write with rd=0 and data=0xFFFFFFFF -> lsu_ready=1 the same cycle, RegWrite stays 0, busy unchanged.
REQ-032 Bench SHALL cover: issue_rd=5, then rs1=5 -> stall=1; ALU write rd=5 accepted -> busy[5] clears at the RegWrite edge and stall=0 the next cycle; issue_rd=5 at that same edge -> busy[5] stays 1.
REQ-033 Bench SHALL cover: rst asserted mid-cycle while a request is granted and busy=0x00000024 -> busy=0, RegWrite=0 and both ready=0 immediately, before the next clk edge.
